// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash responder.
// Holds the serial NOR opcodes this target understands and the
// transaction state enumeration used by the responder FSM.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_RDSR      = 8'h05;
    localparam logic [7:0] OP_RDID      = 8'h9F;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        ID,
        STAT,
        READ,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_target_sync.sv
// Input conditioning for an oversampling SPI target.
// Passes SCK, CS_n and MOSI through SYNC_STAGES flops and derives
// single-cycle edge strobes from the synchronised levels.
// Ports:
//   clk, reset_n          system clock, async active-low reset
//   spi_sck/cs_n/mosi     raw pad inputs
//   sck_rise, sck_fall    SCK edges, only while CS_n is low
//   cs_fall, cs_rise      chip-select edges
//   mosi                  synchronised MOSI level
module spi_target_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic spi_sck,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi
);

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic sck_prev_q, sck_prev_d;
    logic cs_prev_q, cs_prev_d;
    logic sck_s, cs_n_s;

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sck_prev_d  = sck_sync_q[SYNC_STAGES-1];
        cs_prev_d   = cs_sync_q[SYNC_STAGES-1];
    end

    // CS_n resets high so a select already held low at reset release
    // still produces a clean falling-edge strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
        end
    end

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_n_s = cs_sync_q[SYNC_STAGES-1];
    assign mosi   = mosi_sync_q[SYNC_STAGES-1];

    // SCK edges are ignored while deselected so stray clocks on a shared
    // bus cannot advance the bit counter.
    assign sck_rise = sck_s & ~sck_prev_q & ~cs_n_s;
    assign sck_fall = ~sck_s & sck_prev_q & ~cs_n_s;
    assign cs_fall  = ~cs_n_s & cs_prev_q;
    assign cs_rise  = cs_n_s & ~cs_prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 target that mimics a serial NOR flash for the bootloader.
// Answers JEDEC ID (0x9F), status (0x05), read (0x03) and fast read (0x0B)
// from a synchronous byte memory port; all other opcodes are ignored.
// Ports:
//   clk_48mhz, reset_n     system clock, async active-low reset
//   spi_sck/cs_n/mosi      SPI inputs, oversampled
//   spi_miso, spi_miso_oe  SPI output data and pad enable
//   status_in              status byte returned by 0x05
//   mem_addr, mem_rd_en    memory read request (one strobe per byte)
//   mem_rd_data            read data, valid the cycle after mem_rd_en
//   cmd_valid, cmd         opcode-complete pulse and last opcode
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
    parameter int          ADDR_W      = 20,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clk_48mhz,
    input  logic              reset_n,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [7:0]        status_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rd_data,
    output logic              cmd_valid,
    output logic [7:0]        cmd
);

    // The shift register only needs to hold what is eventually used: the
    // opcode and the low ADDR_W address bits. Higher address bits fall off.
    localparam int SH_W = (ADDR_W > 8) ? ADDR_W - 1 : 7;

    logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;

    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [SH_W-1:0]   shift_q, shift_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [1:0]        id_idx_q, id_idx_d;
    logic [7:0]        tx_q, tx_d;
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic              rd_en_q, rd_en_d;
    logic              rd_cap_q, rd_cap_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [7:0]        cmd_q, cmd_d;

    logic              byte_done;
    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] rx_addr;

    spi_target_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk_48mhz),
        .reset_n  (reset_n),
        .spi_sck  (spi_sck),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .mosi     (mosi_s)
    );

    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
    assign rx_byte   = {shift_q[6:0], mosi_s};
    assign rx_addr   = {shift_q[ADDR_W-2:0], mosi_s};

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Transaction sequencing; a deselect always wins.
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (cs_fall) state_d = CMD;
                CMD: begin
                    if (byte_done) begin
                        case (rx_byte)
                            OP_RDID:               state_d = ID;
                            OP_RDSR:               state_d = STAT;
                            OP_READ, OP_FAST_READ: state_d = ADDR;
                            default:               state_d = IGNORE;
                        endcase
                    end
                end
                ADDR: begin
                    if (byte_done && byte_cnt_q == 2'd2)
                        state_d = (cmd_q == OP_FAST_READ) ? DUMMY : READ;
                end
                DUMMY: if (byte_done) state_d = READ;
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath and outputs. Each output byte is loaded on the 8th rise of
    // the byte before it, so its MSB is ready for the very next SCK fall.
    // Read data arrives two cycles after that rise, well inside the
    // minimum SCK half-period.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        id_idx_d    = id_idx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        rd_en_d     = 1'b0;
        rd_cap_d    = rd_en_q;
        mem_addr_d  = mem_addr_q;
        cmd_valid_d = 1'b0;
        cmd_d       = cmd_q;

        if (rd_cap_q) tx_d = mem_rd_data;

        if (cs_rise) begin
            bit_cnt_d = 3'd0;
        end else begin
            if (cs_fall) begin
                bit_cnt_d  = 3'd0;
                byte_cnt_d = 2'd0;
            end
            if (sck_rise && state_q != IDLE) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                shift_d   = {shift_q[SH_W-2:0], mosi_s};
            end
            if (byte_done) begin
                case (state_q)
                    CMD: begin
                        cmd_valid_d = 1'b1;
                        cmd_d       = rx_byte;
                        byte_cnt_d  = 2'd0;
                        if (rx_byte == OP_RDID) begin
                            tx_d     = JEDEC_ID[23:16];
                            id_idx_d = 2'd1;
                        end else if (rx_byte == OP_RDSR) begin
                            tx_d = status_in;
                        end
                    end
                    ADDR: begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd2) begin
                            ptr_d = rx_addr;
                            // Plain read has no dummy byte, so the first
                            // fetch must go out on the last address rise.
                            if (cmd_q == OP_READ) begin
                                rd_en_d    = 1'b1;
                                mem_addr_d = rx_addr;
                                ptr_d      = rx_addr + ADDR_W'(1);
                            end
                        end
                    end
                    DUMMY, READ: begin
                        rd_en_d    = 1'b1;
                        mem_addr_d = ptr_q;
                        ptr_d      = ptr_q + ADDR_W'(1);
                    end
                    ID: begin
                        case (id_idx_q)
                            2'd1:    tx_d = JEDEC_ID[15:8];
                            2'd2:    tx_d = JEDEC_ID[7:0];
                            default: tx_d = JEDEC_ID[23:16];
                        endcase
                        id_idx_d = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
                    end
                    STAT:    tx_d = status_in;
                    default: ;
                endcase
            end
            if (sck_fall && (state_q == ID || state_q == STAT || state_q == READ)) begin
                miso_d = tx_q[7];
                oe_d   = 1'b1;
                tx_d   = {tx_q[6:0], 1'b0};
            end
        end

        // Only the three answering states may drive the pad.
        if (cs_rise || !(state_q == ID || state_q == STAT || state_q == READ)) begin
            miso_d = 1'b0;
            oe_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= 2'd0;
            shift_q     <= '0;
            ptr_q       <= '0;
            id_idx_q    <= 2'd0;
            tx_q        <= 8'd0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_cap_q    <= 1'b0;
            mem_addr_q  <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= 8'd0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            id_idx_q    <= id_idx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            rd_en_q     <= rd_en_d;
            rd_cap_q    <= rd_cap_d;
            mem_addr_q  <= mem_addr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_addr    = mem_addr_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd         = cmd_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: acts as the SPI master,
// models a byte memory returning addr[7:0]^8'hA5 and compares every
// returned byte against an expectation queue.
module tb_spi_flash_responder;
    import spi_flash_pkg::*;

    localparam int ADDR_W      = 20;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;

    logic              clk_48mhz = 1'b0;
    logic              reset_n;
    logic              spi_sck;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic [7:0]        status_in;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [7:0]        mem_rd_data;
    logic              cmd_valid;
    logic [7:0]        cmd;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [7:0]        exp_q[$];
    logic [ADDR_W-1:0] rd_addrs[$];
    int                consec_err = 0;
    int                cmd_pulses = 0;
    logic              rd_prev    = 1'b0;

    always #10 clk_48mhz = ~clk_48mhz;

    spi_flash_responder #(
        .JEDEC_ID    (24'hEF4016),
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_48mhz   (clk_48mhz),
        .reset_n     (reset_n),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .status_in   (status_in),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_data (mem_rd_data),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd)
    );

    // Synchronous memory with one cycle of read latency
    always @(posedge clk_48mhz) begin
        if (mem_rd_en) mem_rd_data <= mem_addr[7:0] ^ 8'hA5;
    end

    // Logs read strobes and opcode pulses
    always @(negedge clk_48mhz) begin
        if (mem_rd_en) begin
            rd_addrs.push_back(mem_addr);
            if (rd_prev) consec_err++;
        end
        rd_prev = mem_rd_en;
        if (cmd_valid) cmd_pulses++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_48mhz);
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic cs_end();
        wait_clks(HALF);
        spi_cs_n = 1'b1;
        wait_clks(12);
    endtask

    // Full mode-0 byte: MISO sampled just before each rising edge
    task automatic spi_byte(input logic [7:0] out_b, output logic [7:0] in_b,
                            output logic oe_any, output logic oe_all);
        in_b   = 8'h00;
        oe_any = 1'b0;
        oe_all = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = out_b[i];
            wait_clks(HALF);
            in_b[i] = spi_miso;
            oe_any  = oe_any | spi_miso_oe;
            oe_all  = oe_all & spi_miso_oe;
            spi_sck = 1'b1;
            wait_clks(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic spi_bits(input logic [7:0] out_b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = out_b[i];
            wait_clks(HALF);
            spi_sck = 1'b1;
            wait_clks(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic recv_expected(input string name, input int n);
        logic [7:0] rx;
        logic       oe_any, oe_all;
        logic [7:0] exp_b;
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, rx, oe_any, oe_all);
            exp_b = exp_q.pop_front();
            check_cnt++;
            if (rx !== exp_b)
                $display("[TB] FAIL %s byte %0d: got %h expected %h", name, i, rx, exp_b);
            else pass_cnt++;
            check_cnt++;
            if (oe_all !== 1'b1)
                $display("[TB] FAIL %s_oe byte %0d: got %b expected 1", name, i, oe_all);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        wait_clks(3);
        check_cnt++; if (spi_miso !== 1'b0)    $display("[TB] FAIL reset_miso: got %b expected 0", spi_miso);    else pass_cnt++;
        check_cnt++; if (spi_miso_oe !== 1'b0) $display("[TB] FAIL reset_oe: got %b expected 0", spi_miso_oe);  else pass_cnt++;
        check_cnt++; if (mem_rd_en !== 1'b0)   $display("[TB] FAIL reset_rd_en: got %b expected 0", mem_rd_en);  else pass_cnt++;
        check_cnt++; if (mem_addr !== '0)      $display("[TB] FAIL reset_addr: got %h expected 0", mem_addr);    else pass_cnt++;
        check_cnt++; if (cmd_valid !== 1'b0)   $display("[TB] FAIL reset_cmd_valid: got %b expected 0", cmd_valid); else pass_cnt++;
        check_cnt++; if (cmd !== 8'h00)        $display("[TB] FAIL reset_cmd: got %h expected 00", cmd);         else pass_cnt++;
        reset_n = 1'b1;
        wait_clks(5);
    endtask

    task automatic test_read_id();
        logic [7:0] rx;
        logic       oe_any, oe_all;
        int         base;
        base = cmd_pulses;
        cs_begin();
        spi_byte(OP_RDID, rx, oe_any, oe_all);
        check_cnt++;
        if (oe_any !== 1'b0) $display("[TB] FAIL rdid_opcode_oe: got %b expected 0", oe_any);
        else pass_cnt++;
        exp_q.push_back(8'hEF); exp_q.push_back(8'h40);
        exp_q.push_back(8'h16); exp_q.push_back(8'hEF);
        recv_expected("rdid", 4);
        cs_end();
        check_cnt++;
        if (cmd_pulses - base !== 1) $display("[TB] FAIL rdid_cmd_pulses: got %0d expected 1", cmd_pulses - base);
        else pass_cnt++;
        check_cnt++;
        if (cmd !== OP_RDID) $display("[TB] FAIL rdid_cmd: got %h expected 9f", cmd);
        else pass_cnt++;
        check_cnt++;
        if (spi_miso_oe !== 1'b0) $display("[TB] FAIL rdid_oe_after_cs: got %b expected 0", spi_miso_oe);
        else pass_cnt++;
    endtask

    task automatic test_status();
        logic [7:0] rx;
        logic       oe_any, oe_all;
        status_in = 8'h01;
        cs_begin();
        spi_byte(OP_RDSR, rx, oe_any, oe_all);
        exp_q.push_back(8'h01); exp_q.push_back(8'h01);
        recv_expected("rdsr", 2);
        // byte 3 is already loaded by now; change lands in byte 4
        status_in = 8'h00;
        exp_q.push_back(8'h01); exp_q.push_back(8'h00);
        recv_expected("rdsr_change", 2);
        cs_end();
    endtask

    task automatic test_read();
        logic [7:0]        rx;
        logic              oe_any, oe_all;
        logic [ADDR_W-1:0] exp_addr[$];
        logic [ADDR_W-1:0] got_a, exp_a;
        rd_addrs.delete();
        cs_begin();
        spi_byte(OP_READ, rx, oe_any, oe_all);
        spi_byte(8'h00, rx, oe_any, oe_all);
        spi_byte(8'h01, rx, oe_any, oe_all);
        spi_byte(8'hFE, rx, oe_any, oe_all);
        exp_q.push_back(8'hFE ^ 8'hA5); exp_q.push_back(8'hFF ^ 8'hA5); exp_q.push_back(8'h00 ^ 8'hA5);
        exp_addr.push_back(20'h001FE); exp_addr.push_back(20'h001FF);
        exp_addr.push_back(20'h00200); exp_addr.push_back(20'h00201);
        recv_expected("read", 3);
        cs_end();
        check_cnt++;
        if (rd_addrs.size() !== 4) $display("[TB] FAIL read_strobes: got %0d expected 4", rd_addrs.size());
        else pass_cnt++;
        while (exp_addr.size() > 0 && rd_addrs.size() > 0) begin
            got_a = rd_addrs.pop_front();
            exp_a = exp_addr.pop_front();
            check_cnt++;
            if (got_a !== exp_a) $display("[TB] FAIL read_addr: got %h expected %h", got_a, exp_a);
            else pass_cnt++;
        end
    endtask

    task automatic test_fast_read_wrap();
        logic [7:0] rx;
        logic       oe_any, oe_all;
        rd_addrs.delete();
        cs_begin();
        spi_byte(OP_FAST_READ, rx, oe_any, oe_all);
        spi_byte(8'h0F, rx, oe_any, oe_all);
        spi_byte(8'hFF, rx, oe_any, oe_all);
        spi_byte(8'hFF, rx, oe_any, oe_all);
        spi_bits(8'h00, 7);
        check_cnt++;
        if (rd_addrs.size() !== 0) $display("[TB] FAIL fast_no_early_read: got %0d expected 0", rd_addrs.size());
        else pass_cnt++;
        check_cnt++;
        if (spi_miso_oe !== 1'b0) $display("[TB] FAIL fast_dummy_oe: got %b expected 0", spi_miso_oe);
        else pass_cnt++;
        spi_bits(8'h00, 1);
        check_cnt++;
        if (rd_addrs.size() !== 1 || rd_addrs[0] !== 20'hFFFFF)
            $display("[TB] FAIL fast_first_addr: got %0d reads expected 1 at fffff", rd_addrs.size());
        else pass_cnt++;
        exp_q.push_back(8'hFF ^ 8'hA5); exp_q.push_back(8'h00 ^ 8'hA5);
        recv_expected("fast", 2);
        cs_end();
        check_cnt++;
        if (rd_addrs.size() < 2 || rd_addrs[1] !== 20'h00000)
            $display("[TB] FAIL fast_wrap_addr: got %0d reads expected second at 00000", rd_addrs.size());
        else pass_cnt++;
    endtask

    task automatic test_cs_abort();
        logic [7:0] rx;
        logic       oe_any, oe_all;
        rd_addrs.delete();
        cs_begin();
        spi_byte(OP_READ, rx, oe_any, oe_all);
        spi_bits(8'h00, 8);
        spi_bits(8'h00, 5);
        wait_clks(4);
        spi_cs_n = 1'b1;
        wait_clks(SYNC_STAGES + 2);
        check_cnt++;
        if (dut.state_q !== IDLE) $display("[TB] FAIL abort_idle: got %0d expected %0d", dut.state_q, IDLE);
        else pass_cnt++;
        check_cnt++;
        if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0)
            $display("[TB] FAIL abort_pad: got oe=%b miso=%b expected 0 0", spi_miso_oe, spi_miso);
        else pass_cnt++;
        wait_clks(12);
        check_cnt++;
        if (rd_addrs.size() !== 0) $display("[TB] FAIL abort_no_read: got %0d expected 0", rd_addrs.size());
        else pass_cnt++;
        cs_begin();
        spi_byte(OP_RDID, rx, oe_any, oe_all);
        exp_q.push_back(8'hEF); exp_q.push_back(8'h40); exp_q.push_back(8'h16);
        recv_expected("abort_rdid", 3);
        cs_end();
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx;
        logic       oe_any, oe_all;
        cs_begin();
        spi_byte(OP_READ, rx, oe_any, oe_all);
        spi_byte(8'h00, rx, oe_any, oe_all);
        spi_byte(8'h00, rx, oe_any, oe_all);
        spi_byte(8'h10, rx, oe_any, oe_all);
        exp_q.push_back(8'h10 ^ 8'hA5);
        recv_expected("pre_reset", 1);
        spi_bits(8'h00, 4);
        wait_clks(2);
        #3 reset_n = 1'b0;
        #1;
        check_cnt++;
        if ({spi_miso, spi_miso_oe, mem_rd_en, cmd_valid} !== 4'b0000)
            $display("[TB] FAIL async_reset_bits: got %b expected 0000", {spi_miso, spi_miso_oe, mem_rd_en, cmd_valid});
        else pass_cnt++;
        check_cnt++;
        if (mem_addr !== '0 || cmd !== 8'h00)
            $display("[TB] FAIL async_reset_regs: got addr=%h cmd=%h expected 0 00", mem_addr, cmd);
        else pass_cnt++;
        check_cnt++;
        if (dut.state_q !== IDLE) $display("[TB] FAIL async_reset_state: got %0d expected %0d", dut.state_q, IDLE);
        else pass_cnt++;
        spi_cs_n = 1'b1;
        wait_clks(5);
        reset_n = 1'b1;
        wait_clks(5);
        cs_begin();
        spi_byte(8'h42, rx, oe_any, oe_all);
        for (int i = 0; i < 3; i++) begin
            spi_byte(8'hC3, rx, oe_any, oe_all);
            check_cnt++;
            if (oe_any !== 1'b0) $display("[TB] FAIL ignore_oe byte %0d: got %b expected 0", i, oe_any);
            else pass_cnt++;
        end
        check_cnt++;
        if (cmd !== 8'h42) $display("[TB] FAIL ignore_cmd: got %h expected 42", cmd);
        else pass_cnt++;
        cs_end();
    endtask

    task automatic test_strobe_spacing();
        check_cnt++;
        if (consec_err !== 0) $display("[TB] FAIL rd_en_back_to_back: got %0d expected 0", consec_err);
        else pass_cnt++;
    endtask

    initial begin
        reset_n   = 1'b0;
        spi_sck   = 1'b0;
        spi_cs_n  = 1'b1;
        spi_mosi  = 1'b0;
        status_in = 8'h00;
        $display("[TB] starting spi_flash_responder bench");
        test_reset();
        test_read_id();
        test_status();
        test_read();
        test_fast_read_wrap();
        test_cs_abort();
        test_reset_mid_read();
        test_strobe_spacing();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
